// File: rtl/bus_capture_dump.sv
// -----------------------------------------------------------------------------
// bus_capture_dump
//   Trigger-based capture buffer for bus snooping. While armed, bus samples are
//   written into a circular RAM. A trigger freezes the capture after
//   POST_TRIGGER further samples. The frozen capture is then streamed as bytes
//   over a valid/ready port: 8'hA5, count[15:8], count[7:0], then every stored
//   sample (oldest first) as NB bytes, MSB first, zero-extended to NB*8 bits.
//
// Ports
//   comm_clock    in   sole clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   arm           in   pulse: clear capture and start recording
//   trigger       in   trigger request, honoured only while armed
//   sample_valid  in   strobe: sample_data carries a new bus sample
//   sample_data   in   [BITWIDTH-1:0] bus sample word
//   dump_start    in   pulse: stream out a frozen capture
//   out_valid     out  out_data holds a byte to send
//   out_ready     in   sink accepts the byte when out_valid & out_ready
//   out_data      out  [7:0] dump byte stream
//   busy          out  high in every state except IDLE and DONE
//   capture_done  out  high while a frozen capture waits to be dumped
// -----------------------------------------------------------------------------
module bus_capture_dump #(
  parameter int BITWIDTH     = 32,
  parameter int DEPTH        = 32,
  parameter int POST_TRIGGER = 16
) (
  input  logic                comm_clock,
  input  logic                reset_n,
  input  logic                arm,
  input  logic                trigger,
  input  logic                sample_valid,
  input  logic [BITWIDTH-1:0] sample_data,
  input  logic                dump_start,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic                busy,
  output logic                capture_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NB = (BITWIDTH + 7) / 8;
  localparam int SW = NB * 8;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] POST_C  = CW'(POST_TRIGGER);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_POST, S_DONE, S_HDR, S_DATA
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  post_cnt_q, post_cnt_d;
  logic [CW-1:0]  samp_left_q, samp_left_d;
  logic           trig_pend_q, trig_pend_d;
  logic [1:0]     hdr_idx_q, hdr_idx_d;
  logic [3:0]     byte_left_q, byte_left_d;
  logic [SW-1:0]  sh_q, sh_d;
  logic           out_valid_q, out_valid_d;
  logic [7:0]     out_data_q, out_data_d;
  logic           busy_q, done_q;

  logic [BITWIDTH-1:0] mem [DEPTH];
  logic [BITWIDTH-1:0] rd_word_q;
  logic                ram_we, ram_re;
  logic [AW-1:0]       ram_raddr;

  logic                accept, load_word;
  logic [SW-1:0]       ld_word;
  logic [15:0]         cnt16;
  logic [AW-1:0]       rd_start;

  function automatic logic [SW-1:0] zext(input logic [BITWIDTH-1:0] w);
    return SW'(w);
  endfunction

  assign accept   = out_valid_q & out_ready;
  assign ld_word  = zext(rd_word_q);
  assign cnt16    = 16'(count_q);
  // Once the buffer has wrapped, the write pointer sits on the oldest sample.
  assign rd_start = (count_q == DEPTH_C) ? wr_ptr_q : '0;

  // Sample RAM: written only while recording, read one word ahead of the
  // byte serializer so a fresh word is always waiting in rd_word_q.
  always_ff @(posedge comm_clock) begin
    if (ram_we) mem[wr_ptr_q] <= sample_data;
    if (ram_re) rd_word_q <= mem[ram_raddr];
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    post_cnt_d  = post_cnt_q;
    samp_left_d = samp_left_q;
    trig_pend_d = trig_pend_q;
    hdr_idx_d   = hdr_idx_q;
    byte_left_d = byte_left_q;
    sh_d        = sh_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_raddr   = rd_ptr_q + AW'(1);
    load_word   = 1'b0;

    if (arm && (state_q != S_HDR) && (state_q != S_DATA)) begin
      state_d     = S_ARMED;
      wr_ptr_d    = '0;
      count_d     = '0;
      post_cnt_d  = '0;
      trig_pend_d = 1'b0;
    end else begin
      if ((state_q == S_ARMED || state_q == S_POST) && sample_valid) begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (count_q != DEPTH_C) count_d = count_q + CW'(1);
      end

      case (state_q)
        S_ARMED: begin
          if (sample_valid) begin
            // A trigger seen earlier without a sample makes this sample the
            // trigger sample.
            if (trigger || trig_pend_q) begin
              trig_pend_d = 1'b0;
              post_cnt_d  = '0;
              state_d     = (POST_TRIGGER == 0) ? S_DONE : S_POST;
            end
          end else if (trigger) begin
            trig_pend_d = 1'b1;
          end
        end
        S_POST: begin
          if (sample_valid) begin
            post_cnt_d = post_cnt_q + CW'(1);
            if (post_cnt_q + CW'(1) == POST_C) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (dump_start) begin
            state_d     = S_HDR;
            rd_ptr_d    = rd_start;
            ram_re      = 1'b1;
            ram_raddr   = rd_start;
            hdr_idx_d   = 2'd0;
            out_valid_d = 1'b1;
            out_data_d  = 8'hA5;
          end
        end
        S_HDR: begin
          if (accept) begin
            case (hdr_idx_q)
              2'd0: begin
                out_data_d = cnt16[15:8];
                hdr_idx_d  = 2'd1;
              end
              2'd1: begin
                out_data_d = cnt16[7:0];
                hdr_idx_d  = 2'd2;
              end
              default: begin
                if (count_q == '0) begin
                  out_valid_d = 1'b0;
                  out_data_d  = 8'h00;
                  state_d     = S_IDLE;
                end else begin
                  load_word = 1'b1;
                end
              end
            endcase
          end
        end
        S_DATA: begin
          if (accept) begin
            if (byte_left_q != 4'd0) begin
              out_data_d  = sh_q[SW-1 -: 8];
              sh_d        = sh_q << 8;
              byte_left_d = byte_left_q - 4'd1;
            end else if (samp_left_q == '0) begin
              out_valid_d = 1'b0;
              out_data_d  = 8'h00;
              state_d     = S_IDLE;
            end else begin
              load_word = 1'b1;
            end
          end
        end
        default: ;
      endcase

      // Present the first byte of the prefetched word and fetch the next one.
      if (load_word) begin
        state_d     = S_DATA;
        out_data_d  = ld_word[SW-1 -: 8];
        sh_d        = ld_word << 8;
        byte_left_d = 4'(NB - 1);
        samp_left_d = (state_q == S_HDR) ? count_q - CW'(1) : samp_left_q - CW'(1);
        ram_re      = 1'b1;
        ram_raddr   = rd_ptr_q + AW'(1);
        rd_ptr_d    = rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      post_cnt_q  <= '0;
      samp_left_q <= '0;
      trig_pend_q <= 1'b0;
      hdr_idx_q   <= 2'd0;
      byte_left_q <= 4'd0;
      sh_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      post_cnt_q  <= post_cnt_d;
      samp_left_q <= samp_left_d;
      trig_pend_q <= trig_pend_d;
      hdr_idx_q   <= hdr_idx_d;
      byte_left_q <= byte_left_d;
      sh_q        <= sh_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign busy         = busy_q;
  assign capture_done = done_q;

endmodule
